// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding, default sizes and vote counter width helper
package puf_pkg;
  typedef enum logic [1:0] {IDLE, PRE, RACE, DONE} state_t;
  localparam int PUF_N_BITS = 64;
  localparam int PUF_CHAL_W = 64;
  localparam int PUF_SETTLE = 8;
  localparam int PUF_VOTES = 5;
  function automatic int vote_cnt_w(input int votes);
    return $clog2(votes + 1);
  endfunction
endpackage

// File: rtl/puf_vote_cnt.sv
// puf_vote_cnt: per-bit vote counter with majority and instability decode of the next count
module puf_vote_cnt
  import puf_pkg::*;
#(
  parameter int VOTES = PUF_VOTES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic q,
  output logic maj,
  output logic unst
);
  localparam int CW = vote_cnt_w(VOTES);
  logic [CW-1:0] cnt, cnt_nxt;
  assign cnt_nxt = cnt + CW'(q);
  assign maj = cnt_nxt > CW'(VOTES / 2);
  assign unst = cnt_nxt != '0 && cnt_nxt != CW'(VOTES);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt_nxt;
endmodule

// File: rtl/puf_response_engine.sv
// puf_response_engine: runs VOTES precharge/race evaluations per challenge and majority-votes the arbiter outputs
module puf_response_engine
  import puf_pkg::*;
#(
  parameter int N_BITS = PUF_N_BITS,
  parameter int CHAL_W = PUF_CHAL_W,
  parameter int SETTLE = PUF_SETTLE,
  parameter int VOTES = PUF_VOTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chal_valid,
  output logic              chal_ready,
  input  logic [CHAL_W-1:0] chal,
  output logic [CHAL_W-1:0] arb_c,
  output logic              launch,
  input  logic [N_BITS-1:0] arb_q,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N_BITS-1:0] resp,
  output logic [N_BITS-1:0] unstable
);
  localparam int EW = vote_cnt_w(VOTES);
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  if (VOTES < 1 || VOTES % 2 == 0 || SETTLE < 1) begin : g_bad_params
    $error("puf_response_engine: VOTES must be odd and >= 1, SETTLE >= 1");
  end
  state_t state;
  logic [SW-1:0] settle;
  logic [EW-1:0] evals;
  logic [N_BITS-1:0] maj, unst;
  logic clr, inc;
  assign clr = state == IDLE && chal_valid;
  assign inc = state == RACE && settle == '0;
  for (genvar g = 0; g < N_BITS; g++) begin : g_cnt
    puf_vote_cnt #(.VOTES(VOTES)) u_cnt (
      .clk(clk), .rst(rst), .clr(clr), .inc(inc), .q(arb_q[g]), .maj(maj[g]), .unst(unst[g])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      chal_ready <= 1'b1;
      launch <= 1'b0;
      resp_valid <= 1'b0;
      resp <= '0;
      unstable <= '0;
      arb_c <= '0;
      settle <= '0;
      evals <= '0;
    end else begin
      case (state)
        IDLE: if (chal_valid) begin
          arb_c <= chal;
          evals <= '0;
          chal_ready <= 1'b0;
          state <= PRE;
        end
        PRE: begin
          launch <= 1'b1;
          settle <= SW'(SETTLE - 1);
          state <= RACE;
        end
        RACE: if (settle == '0) begin
          launch <= 1'b0;
          evals <= evals + 1'b1;
          if (evals == EW'(VOTES - 1)) begin
            resp <= maj;
            unstable <= unst;
            resp_valid <= 1'b1;
            state <= DONE;
          end else state <= PRE;
        end else settle <= settle - 1'b1;
        DONE: if (resp_ready) begin
          resp_valid <= 1'b0;
          chal_ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
endmodule
